// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the PWM DAC stage and the counters it shares with
// the upstream sample generators.
package pwm_dac_pkg;

    // Default window length: 125 MHz / 1024 gives roughly a 122 kHz sample rate.
    localparam int DEFAULT_CYCLES_PER_WINDOW = 1024;
    localparam int DEFAULT_CODE_WIDTH        = 10;

    // Operating states of the PWM stage.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a counter that must hold 0 .. cycles-1.
    function automatic int counter_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    // Comparison width: wide enough for the window length itself and for
    // the full code range, so neither operand is truncated.
    function automatic int compare_width(input int cw, input int code_width);
        return ((cw + 1) > code_width) ? (cw + 1) : code_width;
    endfunction

endpackage

// File: rtl/window_counter.sv
// Free-running wrap counter with enable and a terminal-count flag.
// Also used by the upstream generators as their sample-divide counter.
module window_counter #(
    parameter int               WIDTH    = 10,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = (count == TERMINAL);

    // Count up while enabled, returning to zero after the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm_dac_window.sv
// PWM DAC: turns a sample code into a pulse whose width is the code, once per
// fixed-length window, and strobes upstream for the next sample each window.
module pwm_dac_window
    import pwm_dac_pkg::*;
#(
    parameter int CYCLES_PER_WINDOW = DEFAULT_CYCLES_PER_WINDOW,
    parameter int CODE_WIDTH        = DEFAULT_CODE_WIDTH,
    parameter int CW                = counter_width(CYCLES_PER_WINDOW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CODE_WIDTH-1:0] code,
    output logic                  next_sample,
    output logic                  pwm,
    output logic                  sat,
    output logic [CW-1:0]         window_idx
);

    localparam int              CMPW       = compare_width(CW, CODE_WIDTH);
    localparam logic [CMPW-1:0] FULL_SCALE = CMPW'(CYCLES_PER_WINDOW);
    localparam logic [CW-1:0]   LAST_CNT   = CW'(CYCLES_PER_WINDOW - 1);

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic                  tc;
    logic                  run;
    logic [CODE_WIDTH-1:0] code_q;
    logic [CODE_WIDTH-1:0] code_q_next;
    logic                  pwm_next;
    logic                  sat_next;

    assign run = (state == RUN);

    window_counter #(
        .WIDTH   (CW),
        .TERMINAL(LAST_CNT)
    ) u_window_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .count(cnt),
        .tc   (tc)
    );

    // The counter value that will be present in the coming cycle; pwm is
    // registered, so it is computed against this rather than the current count.
    assign cnt_next = run ? (tc ? '0 : cnt + CW'(1)) : cnt;

    assign next_sample = run && tc;
    assign window_idx  = cnt;

    // Next state, code latch and next pwm/sat levels. The code is sampled only
    // at run start and at the window wrap, so mid-window changes are ignored;
    // en is likewise only acted on at the wrap so the current window completes.
    always_comb begin
        state_next  = state;
        code_q_next = code_q;
        pwm_next    = 1'b0;
        sat_next    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next  = RUN;
                    code_q_next = code;
                end
            end
            RUN: begin
                if (tc) begin
                    code_q_next = code;
                    if (!en) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state_next == RUN) begin
            pwm_next = CMPW'(cnt_next) < CMPW'(code_q_next);
            sat_next = CMPW'(code_q_next) >= FULL_SCALE;
        end
    end

    // State, latched code and the registered outputs; reset aborts any window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            code_q <= '0;
            pwm    <= 1'b0;
            sat    <= 1'b0;
        end else begin
            state  <= state_next;
            code_q <= code_q_next;
            pwm    <= pwm_next;
            sat    <= sat_next;
        end
    end

endmodule

// File: tb/tb_pwm_dac_window.sv
// Bench for pwm_dac_window: two instances (1024- and 512-cycle windows) driven
// by directed and random stimulus and compared each cycle to a window model.
module tb_pwm_dac_window;

    localparam int N0 = 1024;
    localparam int N1 = 512;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [9:0] code0;
    logic [9:0] code1;
    logic       ns0, pwm0, sat0;
    logic       ns1, pwm1, sat1;
    logic [9:0] idx0;
    logic [8:0] idx1;

    int compared   = 0;
    int mismatched = 0;
    bit checkEnable = 1'b0;

    // Model state per instance: running flag, position in window, latched code.
    bit running [2];
    int k       [2];
    int latched [2];
    int wraps   [2];
    int win     [2] = '{N0, N1};
    int hcount  [2];

    pwm_dac_window #(.CYCLES_PER_WINDOW(N0), .CODE_WIDTH(10)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .code(code0),
        .next_sample(ns0), .pwm(pwm0), .sat(sat0), .window_idx(idx0)
    );

    pwm_dac_window #(.CYCLES_PER_WINDOW(N1), .CODE_WIDTH(10)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .code(code1),
        .next_sample(ns1), .pwm(pwm1), .sat(sat1), .window_idx(idx1)
    );

    // 125 MHz-style clock, period 10 time units.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int minInt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int modelCode(input int i);
        return (i == 0) ? int'(code0) : int'(code1);
    endfunction

    // Window-level reference: a run starts on the first enabled edge, each
    // window is win[i] cycles, the code is taken at start and at every wrap,
    // and a disabled block stops only at the wrap.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                running[i] = 1'b0;
                k[i]       = 0;
                latched[i] = 0;
            end else if (!running[i]) begin
                if (en) begin
                    running[i] = 1'b1;
                    k[i]       = 0;
                    latched[i] = modelCode(i);
                end
            end else if (k[i] == win[i] - 1) begin
                latched[i] = modelCode(i);
                k[i]       = 0;
                wraps[i]   = wraps[i] + 1;
                if (!en) running[i] = 1'b0;
            end else begin
                k[i] = k[i] + 1;
            end
        end
    end

    task automatic checkInstance(input int i, input int p, input int s, input int ns, input int idx);
        int expPwm;
        int expSat;
        int expNs;
        int expIdx;
        expPwm = (running[i] && k[i] < latched[i]) ? 1 : 0;
        expSat = (running[i] && latched[i] >= win[i]) ? 1 : 0;
        expNs  = (running[i] && k[i] == win[i] - 1) ? 1 : 0;
        expIdx = running[i] ? k[i] : 0;
        checkOutput($sformatf("pwm%0d", i), p, expPwm);
        checkOutput($sformatf("sat%0d", i), s, expSat);
        checkOutput($sformatf("next_sample%0d", i), ns, expNs);
        checkOutput($sformatf("window_idx%0d", i), idx, expIdx);
        if (running[i]) begin
            if (k[i] == 0) hcount[i] = 0;
            hcount[i] = hcount[i] + p;
            if (k[i] == win[i] - 1) begin
                checkOutput($sformatf("duty%0d", i), hcount[i], minInt(latched[i], win[i]));
            end
        end
    endtask

    // Compare every output of both instances midway between active edges.
    always @(negedge clk) begin
        if (checkEnable) begin
            checkInstance(0, int'(pwm0), int'(sat0), int'(ns0), int'(idx0));
            checkInstance(1, int'(pwm1), int'(sat1), int'(ns1), int'(idx1));
        end
    end

    function automatic logic [9:0] pickCode(input int n);
        int v;
        case ($urandom_range(0, 5))
            0:       v = 0;
            1:       v = 1;
            2:       v = n - 1;
            3:       v = minInt(n, 1023);
            default: v = int'($urandom_range(0, 1023));
        endcase
        return 10'(v);
    endfunction

    // Run some cycles, optionally changing codes and toggling en at random.
    task automatic applyStimulus(input int cycles, input int codeOdds, input bit toggleEn);
        repeat (cycles) begin
            @(negedge clk);
            if (codeOdds > 0 && $urandom_range(0, codeOdds - 1) == 0) code0 = pickCode(N0);
            if (codeOdds > 0 && $urandom_range(0, codeOdds - 1) == 0) code1 = pickCode(N1);
            if (toggleEn && $urandom_range(0, 2999) == 0) en = ~en;
        end
    endtask

    // Wait (bounded) for a given window position of instance 0.
    task automatic waitForK0(input int target);
        int n;
        n = 0;
        @(negedge clk);
        while (k[0] != target && n < 3 * N0) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_window_pos", k[0], target);
    endtask

    // Square-wave style upstream: advance on each strobe, toggle level every 3.
    task automatic runGenerator(input int windows);
        int seen;
        int step;
        int lastWraps;
        int budget;
        bit high;
        seen = 0;
        step = 0;
        high = 1'b0;
        budget = 0;
        lastWraps = wraps[0];
        code0 = 10'd462;
        while (seen < windows && budget < (windows + 2) * N0) begin
            @(negedge clk);
            budget++;
            if (wraps[0] != lastWraps) begin
                lastWraps = wraps[0];
                seen++;
                step++;
                if (step == 3) begin
                    step = 0;
                    high = ~high;
                    code0 = high ? 10'd562 : 10'd462;
                end
            end
        end
        checkOutput("generator_windows", seen, windows);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        code0 = '0;
        code1 = '0;
        checkEnable = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset release with en=1, code=512 / 700");
        code0 = 10'd512;
        code1 = 10'd700;
        en = 1'b1;
        rst = 1'b0;
        applyStimulus(N0 + 20, 0, 1'b0);

        $display("[TB] code stepped 462 -> 562 at the strobe");
        code0 = 10'd462;
        waitForK0(N0 - 1);
        @(negedge clk);
        code0 = 10'd562;
        applyStimulus(2 * N0, 0, 1'b0);

        $display("[TB] extreme codes");
        code0 = 10'd0;
        code1 = 10'd512;
        applyStimulus(2 * N0, 0, 1'b0);
        code0 = 10'd1023;
        code1 = 10'd511;
        applyStimulus(2 * N0, 0, 1'b0);

        $display("[TB] en dropped mid-window");
        code0 = 10'd512;
        waitForK0(100);
        en = 1'b0;
        applyStimulus(N0 + 50, 0, 1'b0);
        code0 = 10'd300;
        en = 1'b1;
        applyStimulus(N0 + 10, 0, 1'b0);
        waitForK0(100);
        en = 1'b0;
        waitForK0(600);
        en = 1'b1;
        applyStimulus(N0, 0, 1'b0);

        $display("[TB] asynchronous reset mid-window");
        code0 = 10'd512;
        applyStimulus(N0 + 10, 0, 1'b0);
        waitForK0(300);
        checkOutput("pre_reset_pwm0", int'(pwm0), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_pwm0", int'(pwm0), 0);
        checkOutput("async_sat0", int'(sat0), 0);
        checkOutput("async_ns0", int'(ns0), 0);
        checkOutput("async_idx0", int'(idx0), 0);
        checkOutput("async_pwm1", int'(pwm1), 0);
        checkOutput("async_idx1", int'(idx1), 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(5, 0, 1'b0);
        en = 1'b1;
        applyStimulus(N0 + 10, 0, 1'b0);

        $display("[TB] random codes and en");
        applyStimulus(20 * N0, 40, 1'b1);

        $display("[TB] upstream square-wave source");
        en = 1'b1;
        applyStimulus(2 * N0 + 5, 0, 1'b0);
        runGenerator(12);

        checkEnable = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
